// File: rtl/eeprom_pkg.sv
// -----------------------------------------------------------------------------
// eeprom_pkg
// Shared definitions for the EEPROM self-test command source: FSM state
// encoding, command-type constants and the default EEPROM word-address width.
// No ports (package).
// -----------------------------------------------------------------------------
package eeprom_pkg;

  localparam int unsigned EEPROM_ADDR_WIDTH = 16;

  // Driver command type carried on o_ctrl_type.
  localparam logic CMD_WR = 1'b0;
  localparam logic CMD_RD = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CMD,
    S_WR_DATA,
    S_WR_WAIT,
    S_RD_CMD,
    S_RD_DATA,
    S_FIN
  } state_t;

endpackage

// File: rtl/eeprom_selftest_gen_if.sv
// -----------------------------------------------------------------------------
// eeprom_selftest_gen_if
// Command / write-data / read-data bundle between a command source and the
// EEPROM driver. Signal names carry the command source's point of view.
//   master : command source (drives command + write data, takes ready + read data)
//   slave  : EEPROM driver
// Parameter P_ADDR_WIDTH : width of the EEPROM word address.
// -----------------------------------------------------------------------------
interface eeprom_selftest_gen_if #(
  parameter int unsigned P_ADDR_WIDTH = eeprom_pkg::EEPROM_ADDR_WIDTH
);
  logic [2:0]              o_ctrl_slave_addr;
  logic [P_ADDR_WIDTH-1:0] o_ctrl_rw_addr;
  logic [7:0]              o_ctrl_num;
  logic                    o_ctrl_type;
  logic                    o_ctrl_valid;
  logic                    i_ctrl_ready;
  logic [7:0]              o_ctrl_wr_data;
  logic                    o_ctrl_wr_sop;
  logic                    o_ctrl_wr_eop;
  logic                    o_ctrl_wr_valid;
  logic [7:0]              i_ctrl_rd_data;
  logic                    i_ctrl_rd_valid;

  modport master (
    output o_ctrl_slave_addr, o_ctrl_rw_addr, o_ctrl_num, o_ctrl_type, o_ctrl_valid,
    output o_ctrl_wr_data, o_ctrl_wr_sop, o_ctrl_wr_eop, o_ctrl_wr_valid,
    input  i_ctrl_ready, i_ctrl_rd_data, i_ctrl_rd_valid
  );

  modport slave (
    input  o_ctrl_slave_addr, o_ctrl_rw_addr, o_ctrl_num, o_ctrl_type, o_ctrl_valid,
    input  o_ctrl_wr_data, o_ctrl_wr_sop, o_ctrl_wr_eop, o_ctrl_wr_valid,
    output i_ctrl_ready, i_ctrl_rd_data, i_ctrl_rd_valid
  );
endinterface

// File: rtl/eeprom_pattern_gen.sv
// -----------------------------------------------------------------------------
// eeprom_pattern_gen
// Test pattern byte for a given byte index: data = (P_SEED + idx) mod 256.
// A single instance feeds both the write stream and the read-back compare so
// the two can never disagree on the pattern.
//   idx  in  8  byte index within the transfer
//   data out 8  pattern byte
// -----------------------------------------------------------------------------
module eeprom_pattern_gen #(
  parameter logic [7:0] P_SEED = 8'h5A
) (
  input  logic [7:0] idx,
  output logic [7:0] data
);
  assign data = P_SEED + idx;
endmodule

// File: rtl/eeprom_selftest_gen.sv
// -----------------------------------------------------------------------------
// eeprom_selftest_gen
// EEPROM self-test command source. On i_start it writes a P_LEN-byte
// incrementing pattern at P_START_ADDR, waits P_WR_WAIT cycles for the
// internal write, reads the range back and counts mismatching bytes.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   i_start    in   single-cycle start request (ignored while busy)
//   o_busy     out  high from start accept until the end of o_done
//   o_done     out  one-cycle pulse at test end
//   o_pass     out  last test result, valid from o_done until next start
//   o_err_cnt  out  mismatching bytes in last test, saturating at 255
//   o_timeout  out  read watchdog fired (only with EEPROM_SELFTEST_TIMEOUT_EN)
//   ctrl       master modport towards the EEPROM driver
//
// Optional feature, macro EEPROM_SELFTEST_TIMEOUT_EN: read-phase watchdog of
// P_TIMEOUT cycles that forces a failing finish.
// -----------------------------------------------------------------------------
module eeprom_selftest_gen
  import eeprom_pkg::*;
#(
  parameter int unsigned           P_ADDR_WIDTH = EEPROM_ADDR_WIDTH,
  parameter logic [2:0]            P_SLAVE_ADDR = 3'b000,
  parameter logic [P_ADDR_WIDTH-1:0] P_START_ADDR = '0,
  parameter int unsigned           P_LEN        = 8,
  parameter logic [7:0]            P_SEED       = 8'h5A,
  parameter int unsigned           P_WR_WAIT    = 250000,
  parameter int unsigned           P_TIMEOUT    = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [7:0] o_err_cnt,
`ifdef EEPROM_SELFTEST_TIMEOUT_EN
  output logic       o_timeout,
`endif
  eeprom_selftest_gen_if.master ctrl
);

  if (P_LEN < 1 || P_LEN > 255) begin : g_bad_len
    $error("eeprom_selftest_gen: P_LEN must be 1..255");
  end
  if (P_TIMEOUT == 0) begin : g_bad_timeout
    $error("eeprom_selftest_gen: P_TIMEOUT must be non-zero");
  end

  localparam logic [7:0] LAST_IDX = 8'(P_LEN - 1);

  state_t      state, state_nxt;
  logic [7:0]  idx;        // byte index, shared by write stream and read compare
  logic [31:0] wait_cnt;
  logic [7:0]  err_cnt;
  logic        pass;
  logic [7:0]  exp_byte;
  logic        cmd_hs;
  logic        rd_beat;
  logic        rd_mismatch;
  logic        last_beat;
  logic        wd_expired;

  eeprom_pattern_gen #(.P_SEED(P_SEED)) u_pattern (
    .idx  (idx),
    .data (exp_byte)
  );

  assign cmd_hs      = ctrl.o_ctrl_valid & ctrl.i_ctrl_ready;
  assign rd_beat     = (state == S_RD_DATA) & ctrl.i_ctrl_rd_valid;
  assign rd_mismatch = rd_beat & (ctrl.i_ctrl_rd_data != exp_byte);
  assign last_beat   = (idx == LAST_IDX);

`ifdef EEPROM_SELFTEST_TIMEOUT_EN
  // wd_cnt holds the number of cycles since the last handshake / read byte,
  // so reaching P_TIMEOUT on the next cycle means the limit has elapsed.
  logic [31:0] wd_cnt;
  logic        timeout_q;
  logic        rd_phase;

  assign rd_phase   = (state == S_RD_CMD) | (state == S_RD_DATA);
  assign wd_expired = rd_phase & ~(cmd_hs | rd_beat) & (wd_cnt + 32'd1 >= P_TIMEOUT);
  assign o_timeout  = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!rd_phase)               wd_cnt <= '0;
      else if (cmd_hs || rd_beat)  wd_cnt <= 32'd1;
      else                         wd_cnt <= wd_cnt + 32'd1;

      if (state == S_IDLE && i_start) timeout_q <= 1'b0;
      else if (wd_expired)            timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (i_start)                           state_nxt = S_WR_CMD;
      S_WR_CMD:  if (ctrl.i_ctrl_ready)                 state_nxt = S_WR_DATA;
      S_WR_DATA: if (last_beat)                         state_nxt = S_WR_WAIT;
      S_WR_WAIT: if (wait_cnt + 32'd1 >= P_WR_WAIT)     state_nxt = S_RD_CMD;
      S_RD_CMD:  if (ctrl.i_ctrl_ready)                 state_nxt = S_RD_DATA;
                 else if (wd_expired)                   state_nxt = S_FIN;
      S_RD_DATA: if (rd_beat && last_beat)              state_nxt = S_FIN;
                 else if (wd_expired)                   state_nxt = S_FIN;
      S_FIN:                                            state_nxt = S_IDLE;
      default:                                          state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from state so every field is stable while waiting
  // for ready and returns to its idle value on reset.
  assign ctrl.o_ctrl_slave_addr = P_SLAVE_ADDR;
  assign ctrl.o_ctrl_rw_addr    = P_START_ADDR;
  assign ctrl.o_ctrl_valid      = (state == S_WR_CMD) | (state == S_RD_CMD);
  assign ctrl.o_ctrl_type       = (state == S_RD_CMD) ? CMD_RD : CMD_WR;
  assign ctrl.o_ctrl_num        = ctrl.o_ctrl_valid ? 8'(P_LEN) : 8'h00;
  assign ctrl.o_ctrl_wr_valid   = (state == S_WR_DATA);
  assign ctrl.o_ctrl_wr_data    = ctrl.o_ctrl_wr_valid ? exp_byte : 8'h00;
  assign ctrl.o_ctrl_wr_sop     = ctrl.o_ctrl_wr_valid & (idx == 8'h00);
  assign ctrl.o_ctrl_wr_eop     = ctrl.o_ctrl_wr_valid & last_beat;

  assign o_busy    = (state != S_IDLE);
  assign o_done    = (state == S_FIN);
  assign o_pass    = pass;
  assign o_err_cnt = err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      err_cnt  <= '0;
      pass     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            idx     <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
          end
        end
        S_WR_DATA: begin
          idx      <= last_beat ? 8'h00 : idx + 8'd1;
          wait_cnt <= '0;
        end
        S_WR_WAIT: wait_cnt <= wait_cnt + 32'd1;
        S_RD_CMD:  idx      <= '0;
        S_RD_DATA: begin
          if (rd_beat) idx <= idx + 8'd1;
          if (rd_mismatch && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase

      // Result is latched on entry to FIN so it is visible alongside o_done;
      // a mismatch on the final byte is folded in here since err_cnt lags.
      if (state_nxt == S_FIN && state != S_FIN)
        pass <= ~wd_expired & ~rd_mismatch & (err_cnt == 8'h00);
    end
  end

endmodule

// File: doc/eeprom_selftest_gen.md
Name: eeprom_selftest_gen

Overview:
- Command source sitting directly upstream of the EEPROM driver; drives its UI command, write-data and read-data interfaces.
- On a start pulse:
  - writes a P_LEN-byte incrementing pattern to P_START_ADDR;
  - waits out the EEPROM internal write time;
  - reads the same range back and compares it byte by byte.
- Reports busy, done, pass and error count.
- Used for board bring-up and as the driver's in-system regression stimulus.

Parameters:
- P_ADDR_WIDTH, 16: width of EEPROM word address.
- P_SLAVE_ADDR, 3'b000: A2..A0 device select driven on o_ctrl_slave_addr.
- P_START_ADDR, 16'h0000: first byte address written and read.
- P_LEN, 8: bytes per transfer; legal range 1..255.
- P_SEED, 8'h5A: pattern byte k = (P_SEED + k) mod 256.
- P_WR_WAIT, 250000: idle cycles after write accept before the read command (5 ms at 50 MHz).
- P_TIMEOUT, 1000000: read watchdog in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  single-cycle start request.
- o_busy  out  1  high from start accept until o_done.
- o_done  out  1  one-cycle pulse at test end.
- o_pass  out  1  result of last test, valid from o_done until next start.
- o_err_cnt  out  8  mismatching bytes in last test, saturating at 255.
- o_ctrl_slave_addr  out  3  driver device select.
- o_ctrl_rw_addr  out  P_ADDR_WIDTH  driver start address.
- o_ctrl_num  out  8  driver byte count.
- o_ctrl_type  out  1  0 = write, 1 = read.
- o_ctrl_valid  out  1  command valid.
- i_ctrl_ready  in  1  driver accepts command when valid & ready.
- o_ctrl_wr_data  out  8  write byte.
- o_ctrl_wr_sop  out  1  first write byte.
- o_ctrl_wr_eop  out  1  last write byte.
- o_ctrl_wr_valid  out  1  write byte valid.
- i_ctrl_rd_data  in  8  read byte from driver.
- i_ctrl_rd_valid  in  1  read byte valid.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high (rst).
- Reset values: all outputs 0, except o_ctrl_slave_addr = P_SLAVE_ADDR and o_ctrl_rw_addr = P_START_ADDR (constants). State = IDLE.
- Reset mid-operation abandons the test with no done pulse.
- State sequence: IDLE -> WR_CMD -> WR_DATA -> WR_WAIT -> RD_CMD -> RD_DATA -> FIN -> IDLE.
- IDLE:
  - i_start=1 -> WR_CMD on the next cycle, with o_busy=1, o_err_cnt cleared, o_pass cleared.
  - i_start while busy is ignored.
- WR_CMD:
  - o_ctrl_valid=1, type=0, num=P_LEN.
  - Valid and all command fields are held stable until i_ctrl_ready=1.
  - On handshake -> WR_DATA.
- WR_DATA:
  - P_LEN consecutive cycles of o_ctrl_wr_valid=1, data = P_SEED+k.
  - sop on k=0, eop on k=P_LEN-1; both sop and eop are set when P_LEN=1.
  - No backpressure: the driver buffers the bytes.
  - Then -> WR_WAIT.
- WR_WAIT:
  - 32-bit counter counts P_WR_WAIT cycles after eop.
  - At terminal count -> RD_CMD.
- RD_CMD:
  - Same handshake as WR_CMD, with type=1.
  - On handshake -> RD_DATA, byte index reset to 0.
- RD_DATA:
  - Each i_ctrl_rd_valid compares i_ctrl_rd_data against P_SEED+index.
  - Mismatch increments o_err_cnt, saturating at 255.
  - Index increments on each valid byte.
  - After P_LEN bytes -> FIN.
  - rd_valid in any other state is ignored, including excess bytes after the count is reached.
- FIN (one cycle):
  - o_done=1, o_pass = (err_cnt==0), o_busy=0 on the next cycle.
  - Returns to IDLE; a start on the same cycle as o_done is ignored.
- Byte index and pattern arithmetic are 8-bit, wrapping mod 256.

Optional Feature:
- Macro: EEPROM_SELFTEST_TIMEOUT_EN.
- Defined:
  - Watchdog counter runs in RD_CMD and RD_DATA and is cleared on each handshake or rd_valid.
  - Reaching P_TIMEOUT forces FIN with o_pass=0.
  - Adds port o_timeout (out, 1), set with that o_done and cleared on next start.
- Undefined: no counter and no o_timeout port; the block waits indefinitely.

Decomposition:
- Shared package eeprom_pkg:
  - state encoding enum;
  - command-type constants CMD_WR=1'b0 and CMD_RD=1'b1;
  - default P_ADDR_WIDTH=16.
- One natural sub-module, eeprom_pattern_gen: seed plus index to expected byte. Shared by the write and compare paths so both use an identical pattern.

Test Plan:
- P_LEN=4, P_SEED=8'h5A, P_WR_WAIT=10, ready tied high, read model echoes the written bytes:
  - write bytes 5A 5B 5C 5D, sop on 5A, eop on 5D;
  - then o_done with o_pass=1, o_err_cnt=0.
- Read model corrupts byte 2 to 8'h00 -> o_pass=0, o_err_cnt=1.
- i_ctrl_ready held low 7 cycles in WR_CMD -> valid, addr, num, type stable for all 7 cycles; exactly one write command accepted.
- P_LEN=1 -> a single write beat with sop=eop=1; a read with num=1 completes.
- rst asserted during WR_WAIT -> all outputs at reset values the next cycle, no o_done. A fresh i_start then runs a full test.
- With EEPROM_SELFTEST_TIMEOUT_EN, P_TIMEOUT=50, read model silent -> o_done exactly 50 cycles after the read handshake, o_timeout=1, o_pass=0.
